// File: rtl/iir_pkg.sv
//==============================================================================
// Module      : iir_pkg
// Description : Shared sample width, leak shift and limits for the IIR path.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package iir_pkg;

  localparam int IIR_N = 15;
  localparam int IIR_K = 2;

  typedef logic signed [IIR_N-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(IIR_N-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(IIR_N-1){1'b0}}};

endpackage : iir_pkg

`default_nettype wire

// File: rtl/sat_clip.sv
//==============================================================================
// Module      : sat_clip
// Description : Clips an (N+2)-bit signed value to the N-bit signed range.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module sat_clip
  import iir_pkg::*;
#(
  parameter int N = IIR_N
) (
  input  logic signed [N+1:0] i_val,
  output logic signed [N-1:0] o_val,
  output logic                o_clipped
);

  localparam logic signed [N+1:0] c_MAX_EXT = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] c_MIN_EXT = {3'b111, {(N-1){1'b0}}};

  always_comb begin
    o_val     = i_val[N-1:0];
    o_clipped = 1'b0;
    if (i_val > c_MAX_EXT) begin
      o_val     = {1'b0, {(N-1){1'b1}}};
      o_clipped = 1'b1;
    end else if (i_val < c_MIN_EXT) begin
      o_val     = {1'b1, {(N-1){1'b0}}};
      o_clipped = 1'b1;
    end
  end

endmodule : sat_clip

`default_nettype wire

// File: rtl/iir_inverse_fir.sv
//==============================================================================
// Module      : iir_inverse_fir
// Description : Two-stage inverse of the leaky-integrator IIR, x = y - yp + (yp >>> K).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module iir_inverse_fir
  import iir_pkg::*;
#(
  parameter int N = IIR_N,
  parameter int K = IIR_K
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         sat_flag
);

  logic                r_s1_valid;
  logic [N-1:0]        r_s1_cur;
  logic [N-1:0]        r_s1_prev;
  logic [N-1:0]        r_hist;
  logic                r_out_valid;
  logic [N-1:0]        r_out_data;
  logic                r_sat_flag;

  logic                w_advance;
  logic                w_accept;
  logic signed [N+1:0] w_cur_ext;
  logic signed [N+1:0] w_prev_ext;
  logic signed [N+1:0] w_sum;
  logic signed [N-1:0] w_clip_val;
  logic                w_clipped;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance & ~clear & reset_n;
  assign w_accept  = in_valid & in_ready;

  // N+2 bits covers the full range of cur - prev + (prev >>> K) without wrap.
  assign w_cur_ext  = {{2{r_s1_cur[N-1]}}, r_s1_cur};
  assign w_prev_ext = {{2{r_s1_prev[N-1]}}, r_s1_prev};
  assign w_sum      = w_cur_ext - w_prev_ext + (w_prev_ext >>> K);

  sat_clip #(.N(N)) u_sat_clip (
    .i_val     (w_sum),
    .o_val     (w_clip_val),
    .o_clipped (w_clipped)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_cur    <= '0;
      r_s1_prev   <= '0;
      r_hist      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else if (clear) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_hist      <= '0;
      r_sat_flag  <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      if (w_accept) begin
        r_s1_cur  <= in_data;
        r_s1_prev <= r_hist;
        r_hist    <= in_data;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_clip_val;
        if (w_clipped) begin
          r_sat_flag <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat_flag;

endmodule : iir_inverse_fir

`default_nettype wire

// File: tb/tb_iir_inverse_fir.sv
//==============================================================================
// Module      : tb_iir_inverse_fir
// Description : Directed and round-trip checks for iir_inverse_fir.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_iir_inverse_fir;
  import iir_pkg::*;

  logic    clk = 1'b0;
  logic    reset_n, clear, in_valid, in_ready, out_valid, out_ready, sat_flag;
  sample_t in_data, out_data;

  int      total = 0;
  int      bad   = 0;
  sample_t got[$];
  sample_t exp_q[$];
  logic    drv_done;

  iir_inverse_fir #(.N(IIR_N), .K(IIR_K)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  // Collect every transferred output; clear and reset abort transfers.
  always @(negedge clk) begin
    if (reset_n && !clear && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = sample_t'(v);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk(tag, got[i], exp_q[i]);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int x, y, yp, n, held;
    int xs[$];

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    drv_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_sat_flag", sat_flag, 0);
    chk("reset_in_ready", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Basic: 100,100,100 -> 100,25,25 with 2-cycle latency
    push(100);
    chk("latency_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_valid", out_valid, 1);
    chk("latency_data", out_data, 100);
    push(100);
    push(100);
    exp_q = '{100, 25, 25};
    drain_and_compare("basic");
    chk("basic_sat", sat_flag, 0);

    // Floor shift on negatives
    do_clear();
    push(0); push(-7); push(-7);
    exp_q = '{0, -7, -2};
    drain_and_compare("negfloor");

    // Saturation: 16383 after -16384 would be 28671
    do_clear();
    push(-16384); push(16383);
    exp_q = '{-16384, 16383};
    drain_and_compare("sat");
    chk("sat_flag_set", sat_flag, 1);
    push(16383);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_flag_sticky", sat_flag, 1);
    got.delete();
    do_clear();
    chk("sat_flag_cleared", sat_flag, 0);

    // Backpressure: stream 1..8, stall 5 cycles at first output
    fork
      begin
        for (int i = 1; i <= 8; i++) push(i);
      end
      begin
        n = 0;
        @(posedge clk); #1;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        chk("bp_first_valid", out_valid, 1);
        out_ready = 1'b0;
        held = out_data;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          chk("bp_hold_data", out_data, held);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    exp_q = '{1, 1, 1, 1, 2, 2, 2, 2};
    drain_and_compare("bp");

    // Clear with two samples in flight
    do_clear();
    push(10); push(20);
    clear = 1'b1;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_out_valid", out_valid, 0);
    push(50);
    exp_q = '{50};
    drain_and_compare("clear");
    chk("clear_sat", sat_flag, 0);

    // Reset mid-stream drops everything
    push(300); push(400);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midreset_out_valid", out_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_output", got.size(), 0);
    got.delete();

    // Round trip through a forward IIR model with random gaps
    do_clear();
    yp = 0;
    for (int i = 0; i < 1000; i++) xs.push_back($urandom_range(0, 8000) - 4000);
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          x  = xs[i];
          y  = x + yp - (yp >>> 2);
          yp = y;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          push(y);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    foreach (xs[i]) exp_q.push_back(sample_t'(xs[i]));
    drain_and_compare("roundtrip");
    chk("roundtrip_sat", sat_flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_iir_inverse_fir

`default_nettype wire

// File: doc/iir_inverse_fir.md
Name: iir_inverse_fir

Overview:
- Inverse (deconvolution) filter for the team's first-order leaky-integrator IIR path.
- The forward model is y[n] = x[n] + y[n-1] - (y[n-1] >>> K). This block recovers x[n] = y[n] - y[n-1] + (y[n-1] >>> K) from the filtered stream.
- Sits on the receive side, after the IIR-filtered sample stream. Two-stage pipeline, valid/ready handshake on both ends, saturating signed arithmetic.

Parameters:
- N, 15, sample width in bits; two's-complement signed on both input and output.
- K, 2, leak shift. Must match the forward filter. Legal range 1..N-2.

Ports:
- clk, input, 1, sole clock; all logic on rising edge.
- reset_n, input, 1, reset; synchronous, active-low.
- clear, input, 1, synchronous restart: flushes the pipeline, zeroes history, clears sat_flag.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, N, filtered sample y[n], signed.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- out_data, output, N, recovered sample x[n], signed, saturated.
- sat_flag, output, 1, sticky; set when any output sample was clipped.

Behaviour:
- Reset (reset_n=0 at a clk edge): s1_valid, out_valid, out_data, history h, s1 registers and sat_flag all go to 0.
  - in_ready is 0 while reset_n=0.
  - Reset mid-stream drops all in-flight samples, with no partial output.
- Handshakes:
  - advance = ~out_valid | out_ready.
  - in_ready = advance & ~clear & reset_n (combinational).
  - An input is accepted when in_valid & in_ready.
  - An output is transferred when out_valid & out_ready.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Stage 1, on advance:
  - s1_valid <= accepted.
  - On accept: s1_cur <= in_data, s1_prev <= h, h <= in_data.
  - h changes only on accept.
- Stage 2, on advance:
  - out_valid <= s1_valid.
  - If s1_valid: out_data <= sat(s1_cur - s1_prev + (s1_prev >>> K)).
- Arithmetic:
  - Sign-extend all operands to N+2 bits.
  - >>> is arithmetic (floor toward -inf), e.g. -7 >>> 2 = -2.
  - Clip to [-2^(N-1), 2^(N-1)-1]. When clipping occurs on a valid stage-2 load, set sat_flag <= 1.
- Timing and throughput:
  - Latency is 2 cycles from accept to out_valid, with out_ready held high.
  - Throughput is 1 sample/cycle.
  - Stalls freeze both stages together; no bubbles are inserted and none are collapsed.
- First sample after reset or clear uses h=0, so x[0] = y[0] (saturation still applies).
- clear=1 at an edge:
  - s1_valid, out_valid, h and sat_flag are zeroed.
  - in_ready=0 that cycle, so no accept.
  - An out_valid presented in the same cycle is discarded, even if out_ready=1; downstream must treat clear as an abort.
- reset_n=0 overrides clear.
- in_valid may drop at any time. A gap leaves h unchanged, so history is per-accepted-sample, not per-cycle.

Decomposition:
- Shared package iir_pkg holds:
  - IIR_N = 15 and IIR_K = 2, shared by forward and inverse blocks.
  - Signed sample typedef sample_t of width IIR_N.
  - Constants SAMPLE_MAX and SAMPLE_MIN.
- One natural sub-module, sat_clip: (N+2)-bit signed in, N-bit signed out plus a clipped flag; purely combinational.
  - Instantiated in stage 2 and reusable by the forward IIR.

Test Plan:
- Basic:
  - Stimulus: reset, then K=2, out_ready=1, inputs 100, 100, 100.
  - Required: outputs 100, 25, 25; first out_valid 2 cycles after the first accept; sat_flag=0.
- Negative floor shift:
  - Stimulus: inputs 0, -7, -7.
  - Required: outputs 0, -7, -2.
- Saturation:
  - Stimulus: inputs -16384, 16383.
  - Required: outputs -16384, 16383 (clipped from 28671); sat_flag=1 and stays 1 until clear.
- Backpressure:
  - Stimulus: stream 1..8; hold out_ready=0 for 5 cycles after the first out_valid.
  - Required: out_data held stable; in_ready=0 while stalled; no sample lost or duplicated; golden-model match afterwards.
- Clear mid-stream:
  - Stimulus: assert clear with two samples in flight; next input 50.
  - Required: in-flight samples dropped; output 50 (history zeroed); sat_flag=0.
- Round trip:
  - Stimulus: 1000 random x in ±4000 through a forward-IIR model, then this block, with random in_valid/out_ready gaps.
  - Required: recovered x matches bit-exactly; sat_flag=0.
